// File: rtl/out_acc_wb.sv
// Per-bank read-modify-write accumulator placed in front of the output-memory bank array.
// Define OUT_ACC_SAT_EN to saturate the accumulate on signed overflow; otherwise it wraps.
module out_acc_wb #(
   parameter int unsigned NUM_BANK   = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_BANK-1:0]                 in_valid,
   input  logic [NUM_BANK-1:0]                 in_first,
   input  logic [NUM_BANK-1:0][ADDR_WIDTH-1:0] in_addr,
   input  logic [NUM_BANK-1:0][DATA_WIDTH-1:0] in_data,
   output logic [NUM_BANK-1:0]                 mem_rd_en,
   output logic [NUM_BANK-1:0][ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [NUM_BANK-1:0][DATA_WIDTH-1:0] mem_rd_data,
   output logic [NUM_BANK-1:0]                 mem_wr_en,
   output logic [NUM_BANK-1:0][ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [NUM_BANK-1:0][DATA_WIDTH-1:0] mem_wr_data,
   input  logic                                cnt_clr,
   output logic [CNT_WIDTH-1:0]                wr_cnt,
   output logic                                busy
);

   // S1: captured beat, waiting for the bank read data
   logic [NUM_BANK-1:0]                 s1_valid_q;
   logic [NUM_BANK-1:0]                 s1_first_q;
   logic [NUM_BANK-1:0][ADDR_WIDTH-1:0] s1_addr_q;
   logic [NUM_BANK-1:0][DATA_WIDTH-1:0] s1_data_q;

   // S2: result being written this cycle
   logic [NUM_BANK-1:0]                 s2_valid_q;
   logic [NUM_BANK-1:0][ADDR_WIDTH-1:0] s2_addr_q;
   logic [NUM_BANK-1:0][DATA_WIDTH-1:0] s2_data_q;
   logic [NUM_BANK-1:0][DATA_WIDTH-1:0] s2_data_d;

   // S3: last cycle's write, still invisible to a read-first bank read issued alongside it
   logic [NUM_BANK-1:0]                 s3_valid_q;
   logic [NUM_BANK-1:0][ADDR_WIDTH-1:0] s3_addr_q;
   logic [NUM_BANK-1:0][DATA_WIDTH-1:0] s3_data_q;

   logic [NUM_BANK-1:0][DATA_WIDTH-1:0] old_val;
   logic [CNT_WIDTH-1:0]                wr_beats;
   logic [CNT_WIDTH-1:0]                wr_cnt_q;
   logic [CNT_WIDTH-1:0]                wr_cnt_d;

   function automatic logic [DATA_WIDTH-1:0] acc_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] sum;
      sum = a + b;
`ifdef OUT_ACC_SAT_EN
      // Same-sign operands with a sign flip in the sum clamp towards the operand sign
      if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
         sum = {a[DATA_WIDTH-1], {(DATA_WIDTH-1){~a[DATA_WIDTH-1]}}};
      end
`endif
      return sum;
   endfunction

   // S0 issue: a first beat needs no old value
   always_comb begin
      mem_rd_en   = in_valid & ~in_first & ~{NUM_BANK{rst}};
      mem_rd_addr = in_addr;
   end

   // Old-value select, newest in-flight write wins over older ones and memory
   always_comb begin
      old_val   = '0;
      s2_data_d = '0;
      for (int i = 0; i < int'(NUM_BANK); i++) begin
         if (s2_valid_q[i] && (s2_addr_q[i] == s1_addr_q[i])) begin
            old_val[i] = s2_data_q[i];
         end else if (s3_valid_q[i] && (s3_addr_q[i] == s1_addr_q[i])) begin
            old_val[i] = s3_data_q[i];
         end else begin
            old_val[i] = mem_rd_data[i];
         end
         s2_data_d[i] = s1_first_q[i] ? s1_data_q[i] : acc_add(old_val[i], s1_data_q[i]);
      end
   end

   always_comb begin
      wr_beats = '0;
      for (int i = 0; i < int'(NUM_BANK); i++) begin
         wr_beats = wr_beats + CNT_WIDTH'(s2_valid_q[i]);
      end
      wr_cnt_d = (cnt_clr ? '0 : wr_cnt_q) + wr_beats;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= '0;
         s1_first_q <= '0;
         s1_addr_q  <= '0;
         s1_data_q  <= '0;
         s2_valid_q <= '0;
         s2_addr_q  <= '0;
         s2_data_q  <= '0;
         s3_valid_q <= '0;
         s3_addr_q  <= '0;
         s3_data_q  <= '0;
         wr_cnt_q   <= '0;
      end else begin
         s1_valid_q <= in_valid;
         s1_first_q <= in_first;
         s1_addr_q  <= in_addr;
         s1_data_q  <= in_data;
         s2_valid_q <= s1_valid_q;
         s2_addr_q  <= s1_addr_q;
         s2_data_q  <= s2_data_d;
         s3_valid_q <= s2_valid_q;
         s3_addr_q  <= s2_addr_q;
         s3_data_q  <= s2_data_q;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   always_comb begin
      mem_wr_en   = s2_valid_q;
      mem_wr_addr = s2_addr_q;
      mem_wr_data = s2_data_q;
      wr_cnt      = wr_cnt_q;
      busy        = |{s1_valid_q, s2_valid_q};
   end

endmodule

// File: tb/tb_out_acc_wb.sv
// Directed self-checking bench for out_acc_wb with a read-first, 1-cycle-latency bank model.
// Overflow expectations follow OUT_ACC_SAT_EN in the same way as the design.
module tb_out_acc_wb;

   localparam int NB = 16;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int CW = 32;

`ifdef OUT_ACC_SAT_EN
   localparam logic [DW-1:0] POS_OVF_RES = 32'h7FFF_FFFF;
   localparam logic [DW-1:0] NEG_OVF_RES = 32'h8000_0000;
`else
   localparam logic [DW-1:0] POS_OVF_RES = 32'h8000_0000;
   localparam logic [DW-1:0] NEG_OVF_RES = 32'h7FFF_FFFF;
`endif

   logic                   clk;
   logic                   rst;
   logic [NB-1:0]          in_valid;
   logic [NB-1:0]          in_first;
   logic [NB-1:0][AW-1:0]  in_addr;
   logic [NB-1:0][DW-1:0]  in_data;
   logic [NB-1:0]          mem_rd_en;
   logic [NB-1:0][AW-1:0]  mem_rd_addr;
   logic [NB-1:0][DW-1:0]  mem_rd_data;
   logic [NB-1:0]          mem_wr_en;
   logic [NB-1:0][AW-1:0]  mem_wr_addr;
   logic [NB-1:0][DW-1:0]  mem_wr_data;
   logic                   cnt_clr;
   logic [CW-1:0]          wr_cnt;
   logic                   busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Bank array model: only the low 8 address bits are backed
   logic [DW-1:0] mem [NB][256];
   logic          pre_we;
   int            pre_bank;
   logic [7:0]    pre_addr;
   logic [DW-1:0] pre_data;

   out_acc_wb dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_first    (in_first),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .cnt_clr     (cnt_clr),
      .wr_cnt      (wr_cnt),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (mem_rd_en[b]) mem_rd_data[b] <= mem[b][mem_rd_addr[b][7:0]];
         if (mem_wr_en[b]) mem[b][mem_wr_addr[b][7:0]] <= mem_wr_data[b];
      end
      if (pre_we) mem[pre_bank][pre_addr] <= pre_data;
   end

   task automatic clear_inputs();
      in_valid = '0;
      in_first = '0;
      in_addr  = '0;
      in_data  = '0;
   endtask

   task automatic set_beat(input int b, input logic f, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      in_valid[b] = 1'b1;
      in_first[b] = f;
      in_addr[b]  = a;
      in_data[b]  = d;
   endtask

   // Entered just after a falling edge; returns one falling edge later with the value stored
   task automatic preload(input int b, input logic [7:0] a, input logic [DW-1:0] d);
      pre_bank = b;
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      in_valid = '1;
      #1;
      n_checks++;
      if (mem_rd_en !== '0) begin
         n_fail++; $display("FAIL reset_rd_en_comb: got %h want 0000", mem_rd_en);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (mem_wr_en !== '0) begin
         n_fail++; $display("FAIL reset_wr_en: got %h want 0000", mem_wr_en);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_checks++;
      if (wr_cnt !== '0) begin
         n_fail++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt);
      end
      clear_inputs();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      preload(0, 8'd5, 32'd10);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      set_beat(0, 1'b0, 16'd5, 32'd3);
      #1;
      n_checks++;
      if (mem_rd_en !== 16'h0001 || mem_rd_addr[0] !== 16'd5) begin
         n_fail++; $display("FAIL single_rd: got en=%h addr=%0d want en=0001 addr=5",
                            mem_rd_en, mem_rd_addr[0]);
      end
      @(negedge clk);
      clear_inputs();
      n_checks++;
      if (mem_wr_en !== '0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_t1: got wr_en=%h busy=%b want 0000/1", mem_wr_en, busy);
      end
      @(negedge clk);
      n_checks++;
      if (mem_wr_en !== 16'h0001 || mem_wr_addr[0] !== 16'd5 || mem_wr_data[0] !== 32'd13) begin
         n_fail++; $display("FAIL single_wr: got en=%h addr=%0d data=%0d want 0001/5/13",
                            mem_wr_en, mem_wr_addr[0], mem_wr_data[0]);
      end
      @(negedge clk);
      n_checks++;
      if (wr_cnt !== 32'd1 || busy !== 1'b0 || mem[0][5] !== 32'd13) begin
         n_fail++; $display("FAIL single_after: got cnt=%0d busy=%b mem=%0d want 1/0/13",
                            wr_cnt, busy, mem[0][5]);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_w [4];
      exp_w = '{32'd1, 32'd3, 32'd6, 32'd10};
      for (int k = 0; k < 7; k++) begin
         if (k >= 2 && k <= 5) begin
            n_checks++;
            if (mem_wr_en[0] !== 1'b1 || mem_wr_addr[0] !== 16'd7 ||
                mem_wr_data[0] !== exp_w[k-2]) begin
               n_fail++; $display("FAIL b2b_wr%0d: got en=%b addr=%0d data=%0d want 1/7/%0d",
                                  k - 2, mem_wr_en[0], mem_wr_addr[0], mem_wr_data[0], exp_w[k-2]);
            end
         end
         clear_inputs();
         if (k < 4) set_beat(0, (k == 0), 16'd7, 32'(k + 1));
         @(negedge clk);
      end
      n_checks++;
      if (mem[0][7] !== 32'd10) begin
         n_fail++; $display("FAIL b2b_mem: got %0d want 10", mem[0][7]);
      end
   endtask

   task automatic test_s3_forward();
      // Gap 2 forwards from S3; gap 3 reads the committed value back from memory
      for (int gap = 2; gap <= 3; gap++) begin
         preload(1, 8'd9, 32'd100);
         for (int k = 0; k < gap + 4; k++) begin
            if (k == 2 || k == gap + 2) begin
               n_checks++;
               if (mem_wr_en[1] !== 1'b1 || mem_wr_data[1] !== ((k == 2) ? 32'd105 : 32'd110)) begin
                  n_fail++; $display("FAIL gap%0d_wr_k%0d: got en=%b data=%0d want 1/%0d", gap, k,
                                     mem_wr_en[1], mem_wr_data[1], (k == 2) ? 105 : 110);
               end
            end else if (k == 3) begin
               n_checks++;
               if (mem_wr_en[1] !== 1'b0) begin
                  n_fail++; $display("FAIL gap%0d_idle: got en=%b want 0", gap, mem_wr_en[1]);
               end
            end
            clear_inputs();
            if (k == 0 || k == gap) set_beat(1, 1'b0, 16'd9, 32'd5);
            @(negedge clk);
         end
         n_checks++;
         if (mem[1][9] !== 32'd110) begin
            n_fail++; $display("FAIL gap%0d_mem: got %0d want 110", gap, mem[1][9]);
         end
      end
   endtask

   task automatic test_all_banks();
      logic [NB-1:0][DW-1:0] exp_d;
      for (int b = 0; b < NB; b++) exp_d[b] = 32'(b);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k == 2 || k == 9) begin
            n_checks++;
            if (mem_wr_en !== '1 || mem_wr_data !== exp_d || mem_wr_addr[5] !== 16'(18 + k)) begin
               n_fail++; $display("FAIL all_wr_k%0d: got en=%h addr5=%0d want ffff/%0d", k,
                                  mem_wr_en, mem_wr_addr[5], 18 + k);
            end
         end
         clear_inputs();
         if (k < 8) begin
            for (int b = 0; b < NB; b++) set_beat(b, 1'b1, 16'(20 + k), 32'(b));
         end
         @(negedge clk);
      end
      n_checks++;
      if (wr_cnt !== 32'd128) begin
         n_fail++; $display("FAIL all_cnt: got %0d want 128", wr_cnt);
      end
      for (int k = 0; k < 5; k++) begin
         if (k == 3) begin
            n_checks++;
            if (wr_cnt !== 32'd16) begin
               n_fail++; $display("FAIL clr_same_cycle: got %0d want 16", wr_cnt);
            end
         end
         if (k == 4) begin
            n_checks++;
            if (wr_cnt !== 32'd32) begin
               n_fail++; $display("FAIL clr_then_count: got %0d want 32", wr_cnt);
            end
         end
         clear_inputs();
         cnt_clr = (k == 2);
         if (k < 2) begin
            for (int b = 0; b < NB; b++) set_beat(b, 1'b1, 16'd40, 32'(b));
         end
         @(negedge clk);
      end
      cnt_clr = 1'b0;
   endtask

   task automatic test_overflow();
      logic [DW-1:0] pre_v [4];
      logic [DW-1:0] add_v [4];
      logic          fst_v [4];
      logic [DW-1:0] exp_v [4];
      pre_v = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFB, 32'h7FFF_FFFF};
      add_v = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000};
      fst_v = '{1'b0, 1'b0, 1'b0, 1'b1};
      exp_v = '{POS_OVF_RES, NEG_OVF_RES, 32'hFFFF_FFFE, 32'h8000_0000};
      for (int c = 0; c < 4; c++) begin
         preload(2, 8'd0, pre_v[c]);
         set_beat(2, fst_v[c], 16'd0, add_v[c]);
         @(negedge clk);
         clear_inputs();
         @(negedge clk);
         n_checks++;
         if (mem_wr_en[2] !== 1'b1 || mem_wr_data[2] !== exp_v[c]) begin
            n_fail++; $display("FAIL ovf_case%0d: got en=%b data=%h want 1/%h", c,
                               mem_wr_en[2], mem_wr_data[2], exp_v[c]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_flush();
      preload(3, 8'd4, 32'd50);
      set_beat(3, 1'b0, 16'd4, 32'd7);
      @(negedge clk);
      clear_inputs();
      set_beat(3, 1'b0, 16'd4, 32'd8);
      @(negedge clk);
      clear_inputs();
      set_beat(3, 1'b0, 16'd4, 32'd9);
      rst = 1'b1;
      #1;
      n_checks++;
      if (mem_rd_en !== '0) begin
         n_fail++; $display("FAIL flush_rd_en: got %h want 0000", mem_rd_en);
      end
      n_checks++;
      if (mem_wr_en[3] !== 1'b1 || mem_wr_data[3] !== 32'd57) begin
         n_fail++; $display("FAIL flush_pre_edge_wr: got en=%b data=%0d want 1/57",
                            mem_wr_en[3], mem_wr_data[3]);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      n_checks++;
      if (mem_wr_en !== '0 || busy !== 1'b0 || wr_cnt !== '0) begin
         n_fail++; $display("FAIL flush_after_edge: got en=%h busy=%b cnt=%0d want 0000/0/0",
                            mem_wr_en, busy, wr_cnt);
      end
      set_beat(3, 1'b0, 16'd4, 32'd10);
      @(negedge clk);
      clear_inputs();
      n_checks++;
      if (mem_wr_en !== '0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL flush_dropped: got en=%h busy=%b want 0000/1", mem_wr_en, busy);
      end
      @(negedge clk);
      n_checks++;
      if (mem_wr_en !== 16'h0008 || mem_wr_data[3] !== 32'd67) begin
         n_fail++; $display("FAIL flush_next_beat: got en=%h data=%0d want 0008/67",
                            mem_wr_en, mem_wr_data[3]);
      end
      @(negedge clk);
      n_checks++;
      if (mem[3][4] !== 32'd67 || wr_cnt !== 32'd1) begin
         n_fail++; $display("FAIL flush_final: got mem=%0d cnt=%0d want 67/1", mem[3][4], wr_cnt);
      end
   endtask

   initial begin
      pre_we   = 1'b0;
      pre_bank = 0;
      pre_addr = '0;
      pre_data = '0;
      cnt_clr  = 1'b0;
      rst      = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_s3_forward();
      test_all_banks();
      test_overflow();
      test_reset_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
